// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO on a DEPTH x DATA_W register array.
// Pointers are AW+1 bits and wrap modulo 2*DEPTH. Occupancy and all status
// flags are registered from the next-count value, so they always agree with
// count_o. Accept decisions use only registered flags. There is therefore no
// combinational path from a request input to any output.
module sync_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              rd_en_i,
   output logic [DATA_W-1:0] data_o,
   output logic              rd_valid_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic [AW:0]       count_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam logic [AW:0] C_DEPTH  = DEPTH[AW:0];
   localparam logic [AW:0] C_AFULL  = AFULL_TH[AW:0];
   localparam logic [AW:0] C_AEMPTY = AEMPTY_TH[AW:0];
   localparam logic [AW:0] C_ZERO   = '0;
   localparam logic [AW:0] C_ONE    = {{AW{1'b0}}, 1'b1};

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;

   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [AW:0]       w_count_nxt;

   // Accept decisions come from registered flags only.
   always_comb begin
      w_wr_acc    = wr_en_i & ~full_o;
      w_rd_acc    = rd_en_i & ~empty_o;
      w_count_nxt = count_o;
      if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = count_o + C_ONE;
      end else if (!w_wr_acc && w_rd_acc) begin
         w_count_nxt = count_o - C_ONE;
      end
   end

   // Storage array. It is not reset, but no write is accepted while reset is asserted.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr_acc) begin
         r_mem[r_wr_ptr[AW-1:0]] <= data_i;
      end
   end

   // Pointers, occupancy and flags. The flags are derived from the next count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         count_o        <= '0;
         full_o         <= 1'b0;
         empty_o        <= 1'b1;
         almost_full_o  <= 1'b0;
         almost_empty_o <= 1'b1;
         overflow_o     <= 1'b0;
         underflow_o    <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + C_ONE;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + C_ONE;
         end
         count_o        <= w_count_nxt;
         full_o         <= (w_count_nxt == C_DEPTH);
         empty_o        <= (w_count_nxt == C_ZERO);
         almost_full_o  <= (w_count_nxt >= C_AFULL);
         almost_empty_o <= (w_count_nxt <= C_AEMPTY);
         overflow_o     <= wr_en_i & full_o;
         underflow_o    <= rd_en_i & empty_o;
      end
   end

   // Registered read port. data_o holds its last value between accepted reads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_o     <= '0;
         rd_valid_o <= 1'b0;
      end else begin
         rd_valid_o <= w_rd_acc;
         if (w_rd_acc) begin
            data_o <= r_mem[r_rd_ptr[AW-1:0]];
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH=8, DATA_W=8).
// It applies a table of single-cycle vectors and then a few multi-cycle
// sequences: wrap-around streaming, reset while the FIFO holds data, and a
// queue-model traffic run.
module tb_sync_fifo_param;

   logic       clk;
   logic       rst_n;
   logic       wr_en_i;
   logic [7:0] data_i;
   logic       rd_en_i;
   logic [7:0] data_o;
   logic       rd_valid_o;
   logic       full_o;
   logic       empty_o;
   logic       almost_full_o;
   logic       almost_empty_o;
   logic [3:0] count_o;
   logic       overflow_o;
   logic       underflow_o;

   int n_tests = 0;
   int n_fail  = 0;

   sync_fifo_param #(.DATA_W(8), .DEPTH(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr_en_i        (wr_en_i),
      .data_i         (data_i),
      .rd_en_i        (rd_en_i),
      .data_o         (data_o),
      .rd_valid_o     (rd_valid_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o),
      .count_o        (count_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rs;
      logic       wr;
      logic       rd;
      logic [7:0] din;
      int         cnt;
      logic       full;
      logic       empty;
      logic       af;
      logic       ae;
      logic       vld;
      logic [7:0] dout;
      logic       ovf;
      logic       udf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive the inputs, clock one edge, then settle 1 ns past the edge.
   task automatic step(input logic rs, input logic w, input logic r, input logic [7:0] d);
      rst_n   = rs;
      wr_en_i = w;
      rd_en_i = r;
      data_i  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic rs, input logic w, input logic r, input logic [7:0] d,
                      input int cnt, input logic full, input logic empty, input logic af,
                      input logic ae, input logic vld, input logic [7:0] dout,
                      input logic ovf, input logic udf);
      vec_t v;
      v.rs = rs; v.wr = w; v.rd = r; v.din = d; v.cnt = cnt;
      v.full = full; v.empty = empty; v.af = af; v.ae = ae;
      v.vld = vld; v.dout = dout; v.ovf = ovf; v.udf = udf;
      vecs.push_back(v);
   endtask

   task automatic chk_flags(input string tag, input int cnt, input logic vld, input logic [7:0] dout);
      chk({tag, " count"}, 32'(count_o), cnt);
      chk({tag, " valid"}, rd_valid_o, vld);
      chk({tag, " data"}, data_o, dout);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] exp_d;
      logic       w, r, wa, ra;

      rst_n = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; data_i = '0;

      // Reset is held for 2 cycles with a write request present.
      add(0,1,0,8'h11, 0,0,1,0,1, 0,8'h00, 0,0);
      add(0,1,0,8'h22, 0,0,1,0,1, 0,8'h00, 0,0);
      // Fill with 0x01..0x08.
      for (int k = 1; k <= 8; k++)
         add(1,1,0,8'(k), k, k==8, 0, k>=6, k<=2, 0,8'h00, 0,0);
      // Write while full: rejected, with a single overflow pulse.
      add(1,1,0,8'hAA, 8,1,0,1,0, 0,8'h00, 1,0);
      add(1,0,0,8'h00, 8,1,0,1,0, 0,8'h00, 0,0);
      // Drain in order.
      for (int j = 1; j <= 8; j++)
         add(1,0,1,8'h00, 8-j, 0, j==8, (8-j)>=6, (8-j)<=2, 1,8'(j), 0,0);
      add(1,0,0,8'h00, 0,0,1,0,1, 0,8'h08, 0,0);
      // Write and read while empty: the write is accepted and the read is rejected.
      add(1,1,1,8'h5C, 1,0,0,0,1, 0,8'h08, 0,1);
      add(1,0,1,8'h00, 0,0,1,0,1, 1,8'h5C, 0,0);
      add(1,0,1,8'h00, 0,0,1,0,1, 0,8'h5C, 0,1);
      add(1,0,0,8'h00, 0,0,1,0,1, 0,8'h5C, 0,0);

      foreach (vecs[i]) begin
         step(vecs[i].rs, vecs[i].wr, vecs[i].rd, vecs[i].din);
         chk($sformatf("v%0d count", i), 32'(count_o), vecs[i].cnt);
         chk($sformatf("v%0d full", i), full_o, vecs[i].full);
         chk($sformatf("v%0d empty", i), empty_o, vecs[i].empty);
         chk($sformatf("v%0d afull", i), almost_full_o, vecs[i].af);
         chk($sformatf("v%0d aempty", i), almost_empty_o, vecs[i].ae);
         chk($sformatf("v%0d valid", i), rd_valid_o, vecs[i].vld);
         chk($sformatf("v%0d data", i), data_o, vecs[i].dout);
         chk($sformatf("v%0d ovf", i), overflow_o, vecs[i].ovf);
         chk($sformatf("v%0d udf", i), underflow_o, vecs[i].udf);
      end

      // Wrap-around streaming: keep 3 words resident and push/pop together for 20 cycles.
      for (int k = 0; k < 3; k++) step(1,1,0,8'(100+k));
      chk("stream pre count", 32'(count_o), 3);
      for (int i = 0; i < 20; i++) begin
         step(1,1,1,8'(103+i));
         chk_flags($sformatf("stream%0d", i), 3, 1'b1, 8'(100+i));
         chk($sformatf("stream%0d flags", i),
             {full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o}, 6'b000000);
      end
      for (int i = 0; i < 3; i++) begin
         step(1,0,1,8'h00);
         chk_flags($sformatf("stream drain%0d", i), 2-i, 1'b1, 8'(120+i));
      end
      step(1,0,0,8'h00);
      chk("stream empty", empty_o, 1'b1);

      // Reset while holding 5 words. Afterwards only the new word may appear.
      for (int k = 0; k < 5; k++) step(1,1,0,8'(8'h30+k));
      chk("pre-reset count", 32'(count_o), 5);
      step(0,1,0,8'hEE);
      chk_flags("midreset", 0, 1'b0, 8'h00);
      chk("midreset empty", empty_o, 1'b1);
      chk("midreset full", full_o, 1'b0);
      step(1,1,0,8'h77);
      chk("post-reset count", 32'(count_o), 1);
      step(1,0,1,8'h00);
      chk_flags("post-reset read", 0, 1'b1, 8'h77);
      step(1,0,0,8'h00);

      // Mixed traffic checked against a queue model.
      for (int i = 0; i < 300; i++) begin
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 45);
         exp_d = data_o;
         wa = w && (q.size() != 8);
         ra = r && (q.size() != 0);
         if (ra) exp_d = q.pop_front();
         step(1, w, r, 8'(i));
         if (wa) q.push_back(8'(i));
         chk($sformatf("rnd%0d count", i), 32'(count_o), q.size());
         chk($sformatf("rnd%0d valid", i), rd_valid_o, ra);
         chk($sformatf("rnd%0d data", i), data_o, exp_d);
         chk($sformatf("rnd%0d ovf", i), overflow_o, w && !wa);
         chk($sformatf("rnd%0d udf", i), underflow_o, r && !ra);
         chk($sformatf("rnd%0d full", i), full_o, q.size() == 8);
         chk($sformatf("rnd%0d empty", i), empty_o, q.size() == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO built on an internal DEPTH x DATA_W register array.
- Generalises the 8x8 dual-port memory with:
  - configurable width and depth
  - self-managing wrap-around pointers
  - full/empty and programmable almost-full/almost-empty flags
  - occupancy count
  - overflow/underflow error pulses
- Sits between a producer and a consumer in the same clock domain. It is the base FIFO for the project's later async variant.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries; must be a power of two, >=2.
- AFULL_TH, DEPTH-2, almost_full_o asserts when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty_o asserts when count <= AEMPTY_TH.
- Derived: AW = $clog2(DEPTH); pointers are AW+1 bits.

Ports:
- clk  input  1  rising-edge clock for all logic.
- rst_n  input  1  synchronous reset, active-low; sampled on posedge clk.
- wr_en_i  input  1  write request.
- data_i  input  DATA_W  write data, sampled when a write is accepted.
- rd_en_i  input  1  read request.
- data_o  output  DATA_W  registered read data.
- rd_valid_o  output  1  data_o carries a newly popped word this cycle.
- full_o  output  1  count == DEPTH.
- empty_o  output  1  count == 0.
- almost_full_o  output  1  count >= AFULL_TH.
- almost_empty_o  output  1  count <= AEMPTY_TH.
- count_o  output  AW+1  occupancy, range 0..DEPTH.
- overflow_o  output  1  one-cycle pulse: a write was rejected.
- underflow_o  output  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset (rst_n==0 at posedge clk):
  - wr_ptr=0, rd_ptr=0, count_o=0, data_o=0, rd_valid_o=0.
  - empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0.
  - overflow_o=0, underflow_o=0.
  - Memory contents are not reset.
  - Reset overrides any wr_en_i/rd_en_i in the same cycle. Reset mid-stream discards all stored data.
- Write accept: wr_acc = wr_en_i & ~full_o.
  - On accept: mem[wr_ptr[AW-1:0]] <= data_i; wr_ptr <= wr_ptr+1.
- Read accept: rd_acc = rd_en_i & ~empty_o.
  - On accept: data_o <= mem[rd_ptr[AW-1:0]]; rd_ptr <= rd_ptr+1; rd_valid_o <= 1. Otherwise rd_valid_o <= 0.
  - data_o holds its last value when there is no accepted read.
  - Read latency: word appears on data_o and rd_valid_o=1 in the cycle after the accepting edge.
- Flag decisions use registered flags only; no combinational path from wr_en_i/rd_en_i to any output.
- Full plus simultaneous wr_en_i and rd_en_i: read accepted, write rejected, overflow_o pulses, count becomes DEPTH-1.
- Empty plus simultaneous wr_en_i and rd_en_i: write accepted, read rejected, underflow_o pulses, count becomes 1, rd_valid_o stays 0.
- Non-full, non-empty plus both requests: both accepted, count unchanged, flags unchanged.
- Count update: count_o <= count_o + wr_acc - rd_acc.
- Flag registration: all flags are registered and derived from the next count value, so they are always consistent with count_o in the same cycle.
- Pointer wrap:
  - Pointers wrap naturally modulo 2*DEPTH.
  - The MSB distinguishes full (low AW bits equal, MSBs differ) from empty (pointers equal).
  - Full and empty must agree with count_o at all times.
- overflow_o <= wr_en_i & full_o; underflow_o <= rd_en_i & empty_o. Each is a single-cycle pulse per rejected request.
- Ordering: strict first-in-first-out; no word is lost or duplicated across any number of pointer wraps.

Test Plan:
- Reset check, DEPTH=8, DATA_W=8: hold rst_n=0 for 2 cycles with wr_en_i=1 -> count_o=0, empty_o=1, full_o=0, data_o=0x00, no overflow_o.
- Fill then drain:
  - Write 0x01..0x08 on 8 consecutive cycles -> full_o=1 and count_o=8 after the 8th edge; almost_full_o=1 from count 6.
  - Read 8 times -> data_o=0x01..0x08 in order, each with rd_valid_o=1 one cycle after its rd_en_i; empty_o=1 at the end.
- Overflow: with FIFO full, wr_en_i=1 with data 0xAA for 1 cycle -> overflow_o=1 for exactly 1 cycle, count_o stays 8, and a subsequent drain contains no 0xAA.
- Underflow with simultaneous write: FIFO empty, wr_en_i=1 (0x5C) and rd_en_i=1 together -> underflow_o=1, rd_valid_o=0, count_o=1; the next read returns 0x5C.
- Wrap-around streaming: hold count at 3 while pushing and popping simultaneously for 20 cycles with an incrementing pattern -> data_o sequence is exact and in order, count_o stays 3, and no flag toggles.
- Reset mid-operation: with count_o=5, pulse rst_n=0 for 1 cycle -> count_o=0, empty_o=1; a following write of 0x77 and a read returns 0x77.
